// File: rtl/column_plot_arbiter_pkg.sv
// Shared types and constants for the column plot arbiter slice.
package plot_arb_pkg;

  // Arbiter FSM states: IDLE -> ISSUE -> WAIT_ACK -> RELEASE -> IDLE.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int NCOL_DEF = 64;
  localparam int ROWW_DEF = 10;
  localparam int COLOR_W  = 8;
  localparam int TMO_W    = 10;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/column_plot_arbiter_if.sv
// Requester bus and column pixel-write port of the column plot arbiter.
// master: the arbiter itself; slave: requesters plus the column array.
interface column_plot_arbiter_if
  import plot_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int NCOL = NCOL_DEF,
  parameter int COLW = 6,
  parameter int ROWW = ROWW_DEF
);

  logic [NREQ-1:0]         req;
  logic [NREQ*COLW-1:0]    req_col;
  logic [NREQ*ROWW-1:0]    req_row;
  logic [NREQ*COLOR_W-1:0] req_color;
  logic [NREQ-1:0]         done;
  logic                    busy;
  logic [NCOL-1:0]         col_select;
  logic [ROWW-1:0]         row_select;
  logic [COLOR_W-1:0]      pixel_color;
  logic [NCOL-1:0]         return_sig;
  logic                    timeout_err;

  modport master (
    input  req, req_col, req_row, req_color, return_sig,
    output done, busy, col_select, row_select, pixel_color, timeout_err
  );

  modport slave (
    output req, req_col, req_row, req_color, return_sig,
    input  done, busy, col_select, row_select, pixel_color, timeout_err
  );

endinterface

// File: rtl/column_plot_arbiter_rr_picker.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any
);

  logic [IDXW:0] cand;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt_idx = '0;
    any     = |req;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NREQ)) cand = cand - (IDXW+1)'(NREQ);
      if (req[cand[IDXW-1:0]]) gnt_idx = cand[IDXW-1:0];
    end
  end

endmodule

// File: rtl/column_plot_arbiter.sv
// Round-robin arbiter sharing the one-hot column pixel-write port among NREQ
// plot requesters. Optional feature macro: PLOT_TIMEOUT_EN aborts a write whose
// column never acknowledges within TIMEOUT_CYC cycles of WAIT_ACK.
module column_plot_arbiter
  import plot_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int NCOL        = NCOL_DEF,
  parameter int COLW        = 6,
  parameter int ROWW        = ROWW_DEF,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic                  clock,
  input logic                  reset,
  column_plot_arbiter_if.master bus
);

  localparam int IDXW = idx_w(NREQ);

  state_t              state;
  logic [IDXW-1:0]     ptr;
  logic [IDXW-1:0]     gnt_idx;
  logic                any_req;
  logic [IDXW-1:0]     cur_idx;
  logic [COLW-1:0]     cur_col;
  logic [ROWW-1:0]     cur_row;
  logic [COLOR_W-1:0]  cur_color;
  logic [COLW-1:0]     sel_col;
  logic [ROWW-1:0]     sel_row;
  logic [COLOR_W-1:0]  sel_color;
  logic                col_bad;
  logic                ack;
`ifdef PLOT_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_cnt;
`endif

  rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
    .req     (bus.req),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  // Select the winning requester's column, row and colour slices.
  always_comb begin
    sel_col   = '0;
    sel_row   = '0;
    sel_color = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDXW'(i)) begin
        sel_col   = bus.req_col[i*COLW +: COLW];
        sel_row   = bus.req_row[i*ROWW +: ROWW];
        sel_color = bus.req_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // Only the latched column's acknowledge is ever observed.
  assign col_bad  = (int'(cur_col) >= NCOL);
  assign ack      = bus.return_sig[cur_col];
  assign bus.busy = (state != IDLE);

  // Arbitration FSM driving the column handshake; all port outputs registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      ptr             <= '0;
      cur_idx         <= '0;
      cur_col         <= '0;
      cur_row         <= '0;
      cur_color       <= '0;
      bus.col_select  <= '0;
      bus.row_select  <= '0;
      bus.pixel_color <= '0;
      bus.done        <= '0;
      bus.timeout_err <= 1'b0;
`ifdef PLOT_TIMEOUT_EN
      tmo_cnt         <= '0;
`endif
    end else begin
      // NOTE: non-blocking only here; the pulse defaults below are overridden later in the same block.
      bus.done        <= '0;
      bus.timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            cur_idx   <= gnt_idx;
            cur_col   <= sel_col;
            cur_row   <= sel_row;
            cur_color <= sel_color;
            ptr       <= (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (col_bad) begin
            bus.done        <= NREQ'(1) << cur_idx;
            bus.timeout_err <= 1'b1;
            state           <= IDLE;
          end else begin
            bus.col_select  <= NCOL'(1) << cur_col;
            bus.row_select  <= cur_row;
            bus.pixel_color <= cur_color;
            state           <= WAIT_ACK;
`ifdef PLOT_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            bus.col_select <= '0;
            bus.done       <= NREQ'(1) << cur_idx;
            state          <= RELEASE;
          end
`ifdef PLOT_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            bus.col_select  <= '0;
            bus.done        <= NREQ'(1) << cur_idx;
            bus.timeout_err <= 1'b1;
            state           <= RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          // A column still acknowledging must not leak into the next grant.
          if (!ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
